// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: run modes and the
// stage-register update codes driven into the fd/de/ew registers.
package constant;

  // Run mode of the pipeline sequencer.
  typedef enum logic [1:0] {
    STALL = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    STOP  = 2'd3
  } mode_t;

  // Stage-register control. CLR loads a bubble.
  typedef enum logic [1:0] {
    UPD_HOLD = 2'b00,
    UPD_ADV  = 2'b01,
    UPD_CLR  = 2'b10
  } upd_t;

endpackage

// File: rtl/pipeline_ctrl_perf_counters.sv
// Performance counters for the pipeline: EXEC cycles, retired instructions
// and stall cycles. Each counter wraps naturally at 2^CNT_W.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cycle_en,
  input  logic             instret_en,
  input  logic             stall_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] stall_cnt
);

  // Count enabled events; a synchronous reset clears all three counters.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    if (!rstn) begin
      cycle_cnt <= '0;
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      if (cycle_en)   cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instret_en) instret   <= instret   + CNT_W'(1);
      if (stall_en)   stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the fetch/decode/execute pipeline: run-mode FSM,
// multi-cycle execute latency counter, stage update codes, execute start
// pulse and performance counter enables.
module pipeline_ctrl
  import constant::*;
#(
  parameter int LAT_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             aa_received,
  input  logic             load_done,
  input  logic             aa_sent,
  input  logic             de_valid,
  input  logic [LAT_W-1:0] de_wait_time,
  input  logic             de_stop,
  input  logic             uart_busy,
  input  logic             d_hazard,
  input  logic             e_redirect,
  output logic [1:0]       mode,
  output logic [1:0]       fd_update,
  output logic [1:0]       de_update,
  output logic [1:0]       ew_update,
  output logic             e_start,
  output logic             execute_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] stall_cnt
);

  mode_t            state;
  logic [LAT_W-1:0] latency;
  logic             in_exec;
  logic             halt;
  upd_t             fd_upd;
  upd_t             de_upd;
  upd_t             ew_upd;

  assign in_exec = (state == EXEC);

  // Execute completes once the required extra cycles have elapsed and the
  // UART is free; >= also treats an over-counted latency as complete.
  assign execute_done = in_exec && (latency >= de_wait_time) && !uart_busy;
  assign halt         = execute_done && de_stop;

  // Stage update codes: hold while execute is busy, then redirect beats
  // hazard, and a hazard only bubbles de while fd keeps its instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    fd_upd = UPD_CLR;
    de_upd = UPD_CLR;
    ew_upd = UPD_CLR;
    if (in_exec) begin
      if (!execute_done) begin
        fd_upd = UPD_HOLD;
        de_upd = UPD_HOLD;
        ew_upd = UPD_HOLD;
      end else if (e_redirect) begin
        fd_upd = UPD_CLR;
        de_upd = UPD_CLR;
        ew_upd = UPD_ADV;
      end else if (d_hazard) begin
        fd_upd = UPD_HOLD;
        de_upd = UPD_CLR;
        ew_upd = UPD_ADV;
      end else begin
        fd_upd = UPD_ADV;
        de_upd = UPD_ADV;
        ew_upd = UPD_ADV;
      end
    end
  end

  assign fd_update = fd_upd;
  assign de_update = de_upd;
  assign ew_update = ew_upd;
  assign mode      = state;

  // Run-mode FSM with the latency counter and the registered e_start pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= STALL;
      latency <= '0;
      e_start <= 1'b0;
    end else begin
      latency <= '0;
      e_start <= 1'b0;
      case (state)
        STALL: if (aa_received)           state <= LOAD;
        LOAD:  if (load_done && aa_sent)  state <= EXEC;
        EXEC: begin
          if (execute_done)                latency <= '0;
          else if (latency < de_wait_time) latency <= latency + LAT_W'(1);
          else                             latency <= latency;
          // The halt still retires, but no further instruction starts.
          e_start <= execute_done && !halt;
          if (halt) state <= STOP;
        end
        STOP:    state <= STOP;
        default: state <= STALL;
      endcase
    end
  end

  perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf_counters (
    .clk        (clk),
    .rstn       (rstn),
    .cycle_en   (in_exec),
    .instret_en (execute_done && de_valid),
    .stall_en   (in_exec && (!execute_done || (d_hazard && !e_redirect))),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret),
    .stall_cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  import constant::*;

  localparam int LAT_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             aa_received, load_done, aa_sent;
  logic             de_valid, de_stop, uart_busy, d_hazard, e_redirect;
  logic [LAT_W-1:0] de_wait_time;
  logic [1:0]       mode, fd_update, de_update, ew_update;
  logic             e_start, execute_done;
  logic [CNT_W-1:0] cycle_cnt, instret, stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected counter values, stepped from hand-given expectations.
  int unsigned exp_cyc   = 0;
  int unsigned exp_ret   = 0;
  int unsigned exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .aa_received  (aa_received),
    .load_done    (load_done),
    .aa_sent      (aa_sent),
    .de_valid     (de_valid),
    .de_wait_time (de_wait_time),
    .de_stop      (de_stop),
    .uart_busy    (uart_busy),
    .d_hazard     (d_hazard),
    .e_redirect   (e_redirect),
    .mode         (mode),
    .fd_update    (fd_update),
    .de_update    (de_update),
    .ew_update    (ew_update),
    .e_start      (e_start),
    .execute_done (execute_done),
    .cycle_cnt    (cycle_cnt),
    .instret      (instret),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] wt;
    logic       busy, haz, redir, valid;
    logic       exp_done;
    logic [1:0] efd, ede, eew;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One EXEC cycle: apply inputs, check combinational outputs, then check
  // registered state and counters after the edge.
  task automatic exec_cycle(input string name, input logic [4:0] wt,
                            input logic busy, input logic haz, input logic redir,
                            input logic valid, input logic stop, input logic exp_done,
                            input logic [1:0] efd, input logic [1:0] ede, input logic [1:0] eew);
    de_wait_time = wt; uart_busy = busy; d_hazard = haz;
    e_redirect = redir; de_valid = valid; de_stop = stop;
    #1;
    check({name, "_done"}, execute_done, exp_done);
    check({name, "_fd"}, fd_update, efd);
    check({name, "_de"}, de_update, ede);
    check({name, "_ew"}, ew_update, eew);
    exp_cyc++;
    if (exp_done && valid) exp_ret++;
    if (!exp_done || (haz && !redir)) exp_stall++;
    next_cycle();
    check({name, "_mode"}, mode, (exp_done && stop) ? STOP : EXEC);
    check({name, "_estart"}, e_start, exp_done && !stop);
    check({name, "_cyc"}, cycle_cnt, exp_cyc);
    check({name, "_ret"}, instret, exp_ret);
    check({name, "_stall"}, stall_cnt, exp_stall);
  endtask

  task automatic check_idle(input string name, input logic [1:0] exp_mode);
    check({name, "_mode"}, mode, exp_mode);
    check({name, "_fd"}, fd_update, UPD_CLR);
    check({name, "_de"}, de_update, UPD_CLR);
    check({name, "_ew"}, ew_update, UPD_CLR);
    check({name, "_done"}, execute_done, 1'b0);
    check({name, "_estart"}, e_start, 1'b0);
  endtask

  task automatic check_counters(input string name);
    check({name, "_cyc"}, cycle_cnt, exp_cyc);
    check({name, "_ret"}, instret, exp_ret);
    check({name, "_stall"}, stall_cnt, exp_stall);
  endtask

  // Reset-to-EXEC bring-up with load_done and aa_sent arriving together.
  task automatic enter_exec(input string name);
    aa_received = 1'b1; next_cycle(); aa_received = 1'b0;
    check({name, "_load"}, mode, LOAD);
    load_done = 1'b1; aa_sent = 1'b1; next_cycle();
    load_done = 1'b0; aa_sent = 1'b0;
    check({name, "_exec"}, mode, EXEC);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"hazard",      5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, UPD_HOLD, UPD_CLR,  UPD_ADV};
    vecs[1] = '{"haz_redir",   5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, UPD_CLR,  UPD_CLR,  UPD_ADV};
    vecs[2] = '{"redirect",    5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, UPD_CLR,  UPD_CLR,  UPD_ADV};
    vecs[3] = '{"bubble",      5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, UPD_ADV,  UPD_ADV,  UPD_ADV};
    vecs[4] = '{"plain",       5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, UPD_ADV,  UPD_ADV,  UPD_ADV};
    vecs[5] = '{"busy_haz",    5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD};
    vecs[6] = '{"busy_redir",  5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD};

    rstn = 1'b0; aa_received = 1'b0; load_done = 1'b0; aa_sent = 1'b0;
    de_valid = 1'b0; de_wait_time = '0; de_stop = 1'b0; uart_busy = 1'b0;
    d_hazard = 1'b0; e_redirect = 1'b0;

    // Reset state.
    repeat (2) next_cycle();
    check_idle("reset", STALL);
    check_counters("reset");

    // STALL -> LOAD on aa_received; load_done alone keeps LOAD.
    rstn = 1'b1;
    repeat (2) next_cycle();
    check_idle("stall_idle", STALL);
    aa_received = 1'b1; next_cycle(); aa_received = 1'b0;
    check_idle("to_load", LOAD);
    load_done = 1'b1;
    repeat (2) next_cycle();
    check_idle("load_no_ack", LOAD);
    aa_received = 1'b1; next_cycle(); aa_received = 1'b0;
    check("load_ignore_aa", mode, LOAD);
    aa_sent = 1'b1; next_cycle();
    load_done = 1'b0; aa_sent = 1'b0;
    check("to_exec", mode, EXEC);
    check_counters("exec_entry");

    // Multi-cycle execute: wait_time = 3.
    for (int i = 0; i < 3; i++)
      exec_cycle("lat_wait", 5'd3, 0, 0, 0, 1, 0, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD);
    exec_cycle("lat_done", 5'd3, 0, 0, 0, 1, 0, 1'b1, UPD_ADV, UPD_ADV, UPD_ADV);

    // UART back-pressure with single-cycle issue.
    for (int i = 0; i < 5; i++)
      exec_cycle("uart_busy", 5'd0, 1, 0, 0, 1, 0, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD);
    exec_cycle("uart_free", 5'd0, 0, 0, 0, 1, 0, 1'b1, UPD_ADV, UPD_ADV, UPD_ADV);

    // Priority table.
    for (int i = 0; i < 7; i++)
      exec_cycle(vecs[i].name, vecs[i].wt, vecs[i].busy, vecs[i].haz, vecs[i].redir,
                 vecs[i].valid, 1'b0, vecs[i].exp_done, vecs[i].efd, vecs[i].ede, vecs[i].eew);

    // Latency already past a shortened wait time counts as done.
    for (int i = 0; i < 2; i++)
      exec_cycle("over_wait", 5'd3, 0, 0, 0, 1, 0, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD);
    exec_cycle("over_done", 5'd1, 0, 0, 0, 1, 0, 1'b1, UPD_ADV, UPD_ADV, UPD_ADV);

    // Halt with wait_time = 2: retires, then STOP is terminal.
    for (int i = 0; i < 2; i++)
      exec_cycle("halt_wait", 5'd2, 0, 0, 0, 1, 1, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD);
    exec_cycle("halt_done", 5'd2, 0, 0, 0, 1, 1, 1'b1, UPD_ADV, UPD_ADV, UPD_ADV);
    de_wait_time = '0; de_stop = 1'b0; aa_received = 1'b1; load_done = 1'b1; aa_sent = 1'b1;
    repeat (3) next_cycle();
    aa_received = 1'b0; load_done = 1'b0; aa_sent = 1'b0;
    #1;
    check_idle("stop", STOP);
    check_counters("stop_frozen");

    // Reset mid-EXEC at latency 2 aborts without retiring.
    rstn = 1'b0; next_cycle(); rstn = 1'b1;
    exp_cyc = 0; exp_ret = 0; exp_stall = 0;
    check_idle("stop_reset", STALL);
    check_counters("stop_reset");
    enter_exec("re1");
    for (int i = 0; i < 2; i++)
      exec_cycle("abort_wait", 5'd5, 0, 0, 0, 1, 0, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD);
    rstn = 1'b0; next_cycle(); rstn = 1'b1;
    exp_cyc = 0; exp_ret = 0; exp_stall = 0;
    #1;
    check_idle("abort", STALL);
    check_counters("abort");

    // Latency restarts from zero after the abort.
    enter_exec("re2");
    for (int i = 0; i < 2; i++)
      exec_cycle("restart_wait", 5'd2, 0, 0, 0, 1, 0, 1'b0, UPD_HOLD, UPD_HOLD, UPD_HOLD);
    exec_cycle("restart_done", 5'd2, 0, 0, 0, 1, 0, 1'b1, UPD_ADV, UPD_ADV, UPD_ADV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
